// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants for the RV32I core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Hazard controller memory-handshake state.
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    // x0 is hardwired to zero, so it never carries a dependency.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Major opcodes shared with the decoder.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Load-use comparator: ID source registers against the load sitting in EX.
// Latency: purely combinational.
// Backpressure: none; the caller decides what to stall.
module pipe_hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    output logic       load_use
);

    logic hit_rs1;
    logic hit_rs2;

    // A load into x0 produces nothing to wait for.
    always_comb begin
        hit_rs1  = id_use_rs1 && (id_rs1 == ex_rd);
        hit_rs2  = id_use_rs2 && (id_rs2 == ex_rd);
        load_use = ex_memread && (ex_rd != REG_X0) && (hit_rs1 || hit_rs2);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: load-use stall, EX redirect flush, data-memory freeze with timeout.
// Latency: Mealy outputs, same cycle; load-use costs 1 bubble, N-cycle memory freezes N-1 cycles.
// Backpressure: dmem_ready low freezes the back end; optional perf counters under PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             ex_redirect,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t       state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_inc;
    logic [4:0]        ex_rd;
    logic              ex_regwrite, ex_memread, ex_mem;
    logic              mem_acc;
    logic              load_use;
    logic              mem_stall;
    logic              timeout;

    pipe_hazard_cmp u_cmp (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_memread (ex_memread),
        .load_use   (load_use)
    );

    // Next state and control outputs; memory freeze beats redirect beats load-use.
    always_comb begin
        state_nxt  = state;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_hold  = 1'b0;
        dmem_req   = mem_acc;
        wait_inc   = (wait_cnt == WCNT_LAST) ? wait_cnt : wait_cnt + WCNT_W'(1);
        timeout    = 1'b0;
        mem_stall  = mem_acc && !dmem_ready;

        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                dmem_req  = 1'b1;
                mem_stall = !dmem_ready;
                if (dmem_ready) begin
                    state_nxt = RUN;
                end else if (wait_inc == WCNT_LAST) begin
                    // Give up on the access; the freeze still covers this cycle.
                    timeout   = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase

        if (mem_stall) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == RUN) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_inc;
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Shadow copies of the ID/EX and EX/MEM control fields; frozen while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_mem      <= 1'b0;
            mem_acc     <= 1'b0;
        end else if (timeout) begin
            mem_acc <= 1'b0;
        end else if (!pipe_hold) begin
            mem_acc <= ex_mem;
            if (idex_flush) begin
                ex_rd       <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_mem      <= 1'b0;
            end else begin
                ex_rd       <= id_valid ? id_rd : 5'd0;
                ex_regwrite <= id_valid && id_regwrite;
                ex_memread  <= id_valid && id_memread;
                ex_mem      <= id_valid && (id_memread || id_memwrite);
            end
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // Free-running performance counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (ifid_flush) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, x0, redirect, memory freeze, timeout, reset.
// Latency: one directed step per clock, outputs sampled mid-cycle.
// Backpressure: dmem_ready driven directly by the stimulus.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic        id_regwrite, id_memread, id_memwrite;
    logic        ex_redirect;
    logic        dmem_ready;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, dmem_req, mem_err;
    logic [31:0] stall_cycles, flush_count;

    int n_vec;
    int n_err;
    int exp_stall;
    int exp_flush;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (8),
        .CNT_W       (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .id_memwrite  (id_memwrite),
        .ex_redirect  (ex_redirect),
        .dmem_ready   (dmem_ready),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .pipe_hold    (pipe_hold),
        .dmem_req     (dmem_req),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw);
        id_valid    = v;
        id_rs1      = rs1;
        id_use_rs1  = u1;
        id_rs2      = rs2;
        id_use_rs2  = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        id_memwrite = mw;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_outs(input string tag, input logic e_pc, input logic e_ifid,
                              input logic e_ifl, input logic e_idf, input logic e_hold,
                              input logic e_req, input logic e_err);
        chk({tag, " pc_write"},   32'(pc_write),   32'(e_pc));
        chk({tag, " ifid_write"}, 32'(ifid_write), 32'(e_ifid));
        chk({tag, " ifid_flush"}, 32'(ifid_flush), 32'(e_ifl));
        chk({tag, " idex_flush"}, 32'(idex_flush), 32'(e_idf));
        chk({tag, " pipe_hold"},  32'(pipe_hold),  32'(e_hold));
        chk({tag, " dmem_req"},   32'(dmem_req),   32'(e_req));
        chk({tag, " mem_err"},    32'(mem_err),    32'(e_err));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        chk({tag, " stall_cycles"}, stall_cycles, 32'(exp_stall));
        chk({tag, " flush_count"},  flush_count,  32'(exp_flush));
`else
        chk({tag, " stall_cycles"}, stall_cycles, 32'd0);
        chk({tag, " flush_count"},  flush_count,  32'd0);
`endif
    endtask

    // Inputs are already driven (posedge+1); sample at mid-cycle, then advance one clock.
    task automatic step(input string tag, input logic e_pc, input logic e_ifid,
                        input logic e_ifl, input logic e_idf, input logic e_hold,
                        input logic e_req, input logic e_err);
        #4;
        check_outs(tag, e_pc, e_ifid, e_ifl, e_idf, e_hold, e_req, e_err);
        if (!e_pc) exp_stall++;
        if (e_ifl) exp_flush++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_stall = 0;
        exp_flush = 0;
        rst_n = 1'b0;
        ex_redirect = 1'b0;
        dmem_ready = 1'b1;
        nop();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lw x5,0(x2) then add x6,x5,x1: one bubble, add issues next cycle
        set_id(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0);
        step("lw_x5", 1, 1, 0, 0, 0, 0, 0);
        set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
        step("lu_stall", 0, 0, 0, 1, 0, 0, 0);
        step("lu_issue", 1, 1, 0, 0, 0, 1, 0);
        nop();
        step("lu_after", 1, 1, 0, 0, 0, 0, 0);

        // lw x0 then add x6,x0,x1: no stall
        set_id(1, 5'd2, 1, 5'd0, 0, 5'd0, 1, 1, 0);
        step("lw_x0", 1, 1, 0, 0, 0, 0, 0);
        set_id(1, 5'd0, 1, 5'd1, 1, 5'd6, 1, 0, 0);
        step("x0_nostall", 1, 1, 0, 0, 0, 0, 0);
        nop();
        step("x0_memdone", 1, 1, 0, 0, 0, 1, 0);

        // Redirect wins over a simultaneous load-use
        set_id(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0);
        step("lw_x7", 1, 1, 0, 0, 0, 0, 0);
        set_id(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0);
        ex_redirect = 1'b1;
        step("redir_over_lu", 1, 1, 1, 1, 0, 0, 0);
        ex_redirect = 1'b0;
        nop();
        step("redir_after", 1, 1, 0, 0, 0, 1, 0);

        // sw with ready low 3 cycles; redirect raised during the freeze lands on release
        set_id(1, 5'd2, 1, 5'd3, 1, 5'd0, 0, 0, 1);
        step("sw_id", 1, 1, 0, 0, 0, 0, 0);
        nop();
        step("sw_ex", 1, 1, 0, 0, 0, 0, 0);
        dmem_ready = 1'b0;
        step("sw_wait1", 0, 0, 0, 0, 1, 1, 0);
        step("sw_wait2", 0, 0, 0, 0, 1, 1, 0);
        ex_redirect = 1'b1;
        step("sw_wait3_redir", 0, 0, 0, 0, 1, 1, 0);
        dmem_ready = 1'b1;
        step("sw_release_redir", 1, 1, 1, 1, 0, 1, 0);
        ex_redirect = 1'b0;
        step("sw_after", 1, 1, 0, 0, 0, 0, 0);

        // Ready never comes: 8 request cycles, then mem_err sticks and the pipe resumes
        set_id(1, 5'd2, 1, 5'd0, 0, 5'd9, 1, 1, 0);
        step("to_lw_id", 1, 1, 0, 0, 0, 0, 0);
        nop();
        step("to_lw_ex", 1, 1, 0, 0, 0, 0, 0);
        dmem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step($sformatf("to_wait%0d", i), 0, 0, 0, 0, 1, 1, 0);
        end
        step("to_resume", 1, 1, 0, 0, 0, 0, 1);
        step("to_sticky", 1, 1, 0, 0, 0, 0, 1);

        // Reset pulsed in the middle of a MEM_WAIT
        dmem_ready = 1'b1;
        set_id(1, 5'd2, 1, 5'd3, 1, 5'd0, 0, 0, 1);
        step("rst_sw_id", 1, 1, 0, 0, 0, 0, 1);
        nop();
        step("rst_sw_ex", 1, 1, 0, 0, 0, 0, 1);
        dmem_ready = 1'b0;
        step("rst_wait1", 0, 0, 0, 0, 1, 1, 1);
        step("rst_wait2", 0, 0, 0, 0, 1, 1, 1);
        #2;
        rst_n = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        #1;
        check_outs("rst_mid_wait", 1, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("rst_after", 1, 1, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the 5-stage RV32I core. It sits beside the ID stage, consuming the decoder's per-instruction control bits, and shadows the ID/EX and EX/MEM control state internally. From that state it drives the PC and pipeline-register enables and flushes. It resolves load-use hazards, EX-stage redirects (taken branch, JAL, JALR) and multi-cycle data-memory handshakes, including a bounded timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum MEM_WAIT cycles before abandoning an access.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5  source register indices.
- id_use_rs1, id_use_rs2  in  1  source actually read.
- id_rd  in  5  destination index.
- id_regwrite, id_memread, id_memwrite  in  1  decoded controls.
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle.
- dmem_ready  in  1  data memory completes the current access.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX loads a bubble.
- pipe_hold  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- dmem_req  out  1  data memory access request.
- mem_err  out  1  sticky timeout flag.
- stall_cycles, flush_count  out  CNT_W  performance counters.

## Operation
- **Shadow registers.** ex_{rd,regwrite,memread,mem} and mem_{acc}, where ex_mem = memread|memwrite.
  - On advance (pipe_hold=0): ex_* ← id_* & id_valid, or zero when idex_flush=1; mem_acc ← ex_mem.
  - When pipe_hold=1, all shadow registers hold.
- **FSM states.** RUN and MEM_WAIT.
  - **RUN:** dmem_req = mem_acc.
    - If mem_acc=1 and dmem_ready=0, go to MEM_WAIT. In this cycle the access is not complete, so pipe_hold=1, pc_write=0 and ifid_write=0.
    - If mem_acc=1 and dmem_ready=1, the access completes and the pipeline advances.
  - **MEM_WAIT:** dmem_req=1, pipe_hold=1, pc_write=0, ifid_write=0, no flushes.
    - dmem_ready=1: go to RUN. The pipeline advances that cycle, with hold released combinationally.
    - Wait counter reaches MEM_TIMEOUT−1 without ready: set mem_err (sticky until reset), clear mem_acc, go to RUN.
- **Priority in RUN** (highest first): memory freeze > redirect > load-use.
  - **Redirect:** ifid_flush=1, idex_flush=1, pc_write=1.
  - **Load-use:** ex_memread & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). Response: pc_write=0, ifid_write=0, idex_flush=1.
  - **Otherwise:** pc_write=1, ifid_write=1, no flush.
- A redirect arriving during a freeze is not lost. EX is frozen, so ex_redirect stays asserted and is applied on the release cycle.
- A register index of x0 never creates a hazard.

## Timing
- Control outputs are Mealy: combinational from state, shadow registers and inputs, valid in the same cycle.
- Load-use inserts exactly 1 bubble.
- A redirect costs 2 flushed slots, both applied in 1 cycle.
- Memory latency of N cycles (ready in the Nth cycle after req) freezes the pipeline for N−1 cycles.
- Wait counter:
  - Width is $clog2(MEM_TIMEOUT).
  - Cleared on entry to MEM_WAIT.
  - Saturating; it cannot wrap.
- Reset (asynchronous, any state, including mid-MEM_WAIT):
  - State goes to RUN; shadow registers, counters and mem_err go to 0.
  - Outputs during and after reset: pc_write=1, ifid_write=1, flushes=0, pipe_hold=0, dmem_req=0, mem_err=0.

## Configuration
- **PIPE_HAZARD_CTRL_PERF_EN defined:**
  - stall_cycles increments on every cycle with pc_write=0.
  - flush_count increments on every redirect.
  - Both wrap modulo 2^CNT_W.
- **Undefined:** both ports are tied to 0 and no counter flops are built. All other behaviour is identical.

## Structure
- **Package pipe_ctrl_pkg** holds:
  - the state enum {RUN, MEM_WAIT};
  - the REG_X0 constant;
  - the opcode constants shared with the decoder.
- **Sub-module pipe_hazard_cmp:** purely combinational load-use comparator (id sources vs ex_rd/ex_memread → load_use). It is reused by the future forwarding unit.

## Test plan
- lw x5 issued, then add x6,x5,x1 in ID → exactly one cycle with pc_write=0, ifid_write=0, idex_flush=1; the add issues the next cycle.
- lw x0 followed by add x6,x0,x1 → no stall.
- ex_redirect=1 with a load-use condition also present → ifid_flush=1, idex_flush=1, pc_write=1; no stall cycle.
- sw with dmem_ready low for 3 cycles → dmem_req high for 4 cycles; pipe_hold and pc_write=0 for 3 cycles; advance on the 4th.
- ready never asserted with MEM_TIMEOUT=8 → mem_err rises after 8 request cycles, stays 1, and the pipeline resumes.
- rst_n pulsed low mid-MEM_WAIT → dmem_req=0 and pc_write=1 immediately; with PERF_EN, counters read 0.
